// File: rtl/bitr45_pkg.sv
// Shared constants and types for the 45-point (3*3*5) digit-reversed reorder buffer.
package bitr45_pkg;

    localparam int N      = 45;
    localparam int ADDR_W = 6;

    // Digit radices, fastest-changing digit first.
    localparam int R0 = 3;
    localparam int R1 = 3;
    localparam int R2 = 5;

    // Storage-address weight of each digit.
    localparam int W0 = 15;
    localparam int W1 = 5;
    localparam int W2 = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

endpackage

// File: rtl/bitr45_mr_counter.sv
// Mixed-radix (3,3,5) counter that walks the digit-reversed address sequence
// r(k) = 15*d0 + 5*d1 + d2, keeping the address incrementally instead of
// multiplying. 'last' flags the final position k = 44.
module bitr45_mr_counter
    import bitr45_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clear,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [1:0] d0;
    logic [1:0] d1;
    logic [2:0] d2;

    logic d0_wrap;
    logic d1_wrap;

    assign d0_wrap = (d0 == 2'(R0 - 1));
    assign d1_wrap = (d1 == 2'(R1 - 1));
    assign last    = d0_wrap && d1_wrap && (d2 == 3'(R2 - 1));

    // Advance the digits; each wrap unwinds the lower digit's weight and adds the next one.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
            addr <= '0;
        end else if (inc) begin
            if (!d0_wrap) begin
                d0   <= d0 + 2'd1;
                addr <= addr + ADDR_W'(W0);
            end else if (!d1_wrap) begin
                d0   <= '0;
                d1   <= d1 + 2'd1;
                addr <= addr - ADDR_W'(2 * W0) + ADDR_W'(W1);
            end else begin
                d0   <= '0;
                d1   <= '0;
                d2   <= (d2 == 3'(R2 - 1)) ? 3'd0 : d2 + 3'd1;
                addr <= addr - ADDR_W'(2 * W0) - ADDR_W'(2 * W1) + ADDR_W'(W2);
            end
        end
    end

endmodule

// File: rtl/bitr45_reorder.sv
// Ping-pong reorder buffer: digit-reversed 45-sample frames in, natural order out.
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and data/last are held while valid && !ready.
module bitr45_reorder
    import bitr45_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             frame_err
);

    logic [WIDTH-1:0] bank0 [N];
    logic [WIDTH-1:0] bank1 [N];

    bank_state_t       flag [2];
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_last;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_end;
    logic              s_hs;
    logic              m_hs;

    // Both ready and valid come from registered flags only, so m_ready never reaches s_ready.
    assign s_ready = rst_n && (flag[wr_bank] == EMPTY);
    assign m_valid = rst_n && (flag[rd_bank] == FULL);
    assign s_hs    = s_valid && s_ready;
    assign m_hs    = m_valid && m_ready;
    assign rd_end  = (rd_addr == ADDR_W'(N - 1));
    assign m_last  = m_valid && rd_end;

    bitr45_mr_counter u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (s_hs && !wr_last),
        .clear (s_hs && wr_last),
        .addr  (wr_addr),
        .last  (wr_last)
    );

    // Sample storage; contents are don't-care until the owning flag says FULL.
    always_ff @(posedge clk) begin
        if (s_hs) begin
            if (wr_bank) bank1[wr_addr] <= s_data;
            else         bank0[wr_addr] <= s_data;
        end
    end

    // Output is zero whenever nothing valid is presented.
    always_comb begin
        m_data = '0;
        if (m_valid) m_data = rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    end

    // Bank flags and pointers; writer and reader always own different banks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag[0] <= EMPTY;
            flag[1] <= EMPTY;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (s_hs && wr_last) begin
                flag[wr_bank] <= FULL;
                wr_bank       <= !wr_bank;
            end
            if (m_hs) begin
                if (rd_end) begin
                    flag[rd_bank] <= EMPTY;
                    rd_bank       <= !rd_bank;
                    rd_addr       <= '0;
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Sticky flag: s_last must coincide exactly with the 45th accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n) frame_err <= 1'b0;
        else if (s_hs && (s_last != wr_last)) frame_err <= 1'b1;
    end

endmodule

// File: tb/tb_bitr45_reorder.sv
// Directed bench for bitr45_reorder: reset, single frame, back-to-back frames,
// full-bank backpressure, random stalls, s_last error and mid-frame reset.
module tb_bitr45_reorder;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             frame_err;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  bitr45_reorder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .frame_err (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // natural bin a came from input position k with r(k) = a
  function automatic int inv(input int a);
    return a / 15 + 3 * ((a / 5) % 3) + 9 * (a % 5);
  endfunction

  function automatic logic [WIDTH-1:0] sample(input int f, input int k);
    return 32'hA500_0000 | (32'(f) << 8) | 32'(k);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_s_ready", s_ready, 1);
    check("rel_m_valid", m_valid, 0);
  endtask

  // driver + scoreboard; starts and ends at a negedge
  task automatic run(input int nf, input int v_pct, input int r_pct, input int lastk,
                     input int fbase, input string nm);
    int in_f = 0;
    int in_k = 0;
    int out_cnt = 0;
    int cyc = 0;
    int last_in_cyc = -1;
    int first_out_cyc = -1;
    int rdy_drops = 0;
    int gaps = 0;
    bit stalled = 0;
    bit err_pend = 0;
    logic [WIDTH-1:0] hold_d = '0;
    logic hold_l = 1'b0;
    exp_q.delete();
    while (out_cnt < nf * 45 && cyc < 20000) begin
      if (stalled) begin
        check({nm, "_hold_valid"}, m_valid, 1);
        check({nm, "_hold_data"}, m_data, hold_d);
        check({nm, "_hold_last"}, m_last, hold_l);
      end
      if (err_pend) begin
        check({nm, "_frame_err_set"}, frame_err, 1);
        err_pend = 0;
      end
      if (!m_valid) check({nm, "_idle_data"}, m_data, 0);
      s_valid = (in_f < nf) && ($urandom_range(0, 99) < v_pct);
      s_data  = s_valid ? sample(fbase + in_f, in_k) : '0;
      s_last  = s_valid && (in_k == lastk);
      m_ready = ($urandom_range(0, 99) < r_pct);
      if (in_f > 0 && in_f < nf && !s_ready) rdy_drops++;
      if (first_out_cyc >= 0 && !m_valid) gaps++;
      if (m_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check({nm, "_spurious"}, m_valid, 0);
        end else begin
          check({nm, "_data"}, m_data, exp_q.pop_front());
          check({nm, "_last"}, m_last, ((out_cnt % 45) == 44));
        end
        out_cnt++;
      end
      stalled = m_valid && !m_ready;
      hold_d  = m_data;
      hold_l  = m_last;
      if (s_valid && s_ready) begin
        if (s_last && in_k != 44) err_pend = 1;
        if (in_k == 44) begin
          for (int a = 0; a < 45; a++) exp_q.push_back(sample(fbase + in_f, inv(a)));
          if (in_f == 0) last_in_cyc = cyc;
          in_f++;
          in_k = 0;
        end else begin
          in_k++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    check({nm, "_out_count"}, out_cnt, nf * 45);
    if (v_pct == 100 && r_pct == 100) begin
      check({nm, "_latency"}, first_out_cyc, last_in_cyc + 1);
      check({nm, "_s_ready_drops"}, rdy_drops, 0);
      check({nm, "_gaps"}, gaps, 0);
    end
    @(negedge clk);
    check({nm, "_drained"}, m_valid, 0);
  endtask

  // full-bank backpressure with the consumer stalled
  task automatic backpressure();
    int acc = 0;
    int cyc = 0;
    apply_reset();
    s_valid = 1'b1;
    m_ready = 1'b0;
    while (cyc < 300 && s_ready) begin
      s_data = sample(acc / 45, acc % 45);
      s_last = ((acc % 45) == 44);
      acc++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    check("bp_accepted", acc, 90);
    repeat (3) @(negedge clk);
    check("bp_s_ready_low", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      check("bp_f0_valid", m_valid, 1);
      check("bp_f0_data", m_data, sample(0, inv(i)));
      check("bp_f0_s_ready", s_ready, 0);
      @(negedge clk);
    end
    check("bp_release_s_ready", s_ready, 1);
    for (int i = 0; i < 45; i++) begin
      check("bp_f1_valid", m_valid, 1);
      check("bp_f1_data", m_data, sample(1, inv(i)));
      check("bp_f1_last", m_last, (i == 44));
      @(negedge clk);
    end
    m_ready = 1'b0;
    check("bp_empty", m_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    apply_reset();

    run(1, 100, 100, 44, 0, "single");
    check("single_frame_err", frame_err, 0);

    run(4, 100, 100, 44, 1, "b2b");

    backpressure();

    apply_reset();
    run(20, 50, 50, 44, 10, "rand");
    check("rand_frame_err", frame_err, 0);

    apply_reset();
    run(1, 100, 100, 30, 40, "slast");
    repeat (3) @(negedge clk);
    check("slast_sticky", frame_err, 1);

    // reset after 20 samples of a frame
    apply_reset();
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_data = sample(3, k);
      @(negedge clk);
    end
    s_valid = 1'b0; s_data = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_frame_err", frame_err, 0);
    run(1, 100, 100, 44, 50, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
